// File: rtl/slave_mem_pipelined.sv
// rtl/slave_mem_pipelined.sv - bus-slave word memory with byte strobes, wait states,
// a fixed-latency in-order response pipeline and a zeroing sweep after reset.
module slave_mem_pipelined #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_SIZE     = 4096,
  parameter int READ_LATENCY = 1,
  parameter int WAIT_STATES  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy
);
  localparam int NB        = DATA_WIDTH / 8;
  localparam int OFF_W     = $clog2(NB);
  localparam int MEM_WORDS = MEM_SIZE / NB;
  localparam int SW_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_ACCEPT} state_t;

  state_t                  state_q, state_d;
  logic [SW_W-1:0]         sweep_q, sweep_d;
  logic [2:0]              wcnt_q, wcnt_d;
  logic                    req_ready_q, req_ready_d;
  logic [READ_LATENCY-1:0] pipe_v_q;
  logic [READ_LATENCY-1:0] pipe_err_q;
  logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS];

  logic [31:0]     idx_ext;
  logic [SW_W-1:0] mem_idx;
  logic            in_range;
  logic            accept;
  logic            do_write;

  // Word index is widened so the range test also works when the address space exceeds the array.
  assign idx_ext  = 32'(req_addr[ADDR_WIDTH-1:OFF_W]);
  assign mem_idx  = idx_ext[SW_W-1:0];
  assign in_range = idx_ext < 32'(MEM_WORDS);
  assign accept   = req_valid && req_ready_q;
  assign do_write = accept && req_wen && in_range;

  generate
    if (OFF_W > 0) begin : g_offset
      logic unused_offset;
      assign unused_offset = ^req_addr[OFF_W-1:0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_INIT: begin
        if (sweep_q == SW_W'(MEM_WORDS - 1)) state_d = S_IDLE;
        else                                 sweep_d = sweep_q + SW_W'(1);
      end
      S_IDLE: begin
        if (WAIT_STATES != 0 && req_valid) begin
          state_d = S_WAIT;
          wcnt_d  = 3'(WAIT_STATES);
        end
      end
      S_WAIT: begin
        if (wcnt_q <= 3'd1) state_d = S_ACCEPT;
        else                wcnt_d  = wcnt_q - 3'd1;
      end
      S_ACCEPT: state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase
    req_ready_d = (state_d == S_ACCEPT) || (state_d == S_IDLE && WAIT_STATES == 0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      wcnt_q      <= '0;
      req_ready_q <= 1'b0;
      pipe_v_q    <= '0;
      pipe_err_q  <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pipe_data_q[k] <= '0;
    end else begin
      state_q        <= state_d;
      sweep_q        <= sweep_d;
      wcnt_q         <= wcnt_d;
      req_ready_q    <= req_ready_d;
      pipe_v_q[0]    <= accept;
      pipe_err_q[0]  <= accept && !in_range;
      pipe_data_q[0] <= (accept && !req_wen && in_range) ? mem_q[mem_idx] : '0;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_v_q[k]    <= pipe_v_q[k-1];
        pipe_err_q[k]  <= pipe_err_q[k-1];
        pipe_data_q[k] <= pipe_data_q[k-1];
      end
    end
  end

  // Storage is never reset directly; the INIT sweep clears it one word per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_INIT) begin
        mem_q[sweep_q] <= '0;
      end else if (do_write) begin
        for (int i = 0; i < NB; i++) begin
          if (req_be[i]) mem_q[mem_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = pipe_v_q[READ_LATENCY-1];
  assign rsp_err   = pipe_err_q[READ_LATENCY-1];
  assign rsp_rdata = pipe_data_q[READ_LATENCY-1];
  assign busy      = (state_q == S_INIT) || (|pipe_v_q);

endmodule

// File: tb/tb_slave_mem_pipelined.sv
// tb/tb_slave_mem_pipelined.sv - scoreboard bench for slave_mem_pipelined in three
// configurations: defaults, 13-bit address with latency 3, and two wait states.
module tb_slave_mem_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  rst, v, w, rdy, rv, re, bsy;
  logic [12:0] ad  [3];
  logic [31:0] wd  [3];
  logic [31:0] rd  [3];
  logic [3:0]  bes [3];

  slave_mem_pipelined u_a (
    .clk(clk), .rst(rst[0]), .req_valid(v[0]), .req_ready(rdy[0]), .req_wen(w[0]),
    .req_addr(ad[0][11:0]), .req_wdata(wd[0]), .req_be(bes[0]),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]), .busy(bsy[0]));

  slave_mem_pipelined #(.ADDR_WIDTH(13), .READ_LATENCY(3)) u_b (
    .clk(clk), .rst(rst[1]), .req_valid(v[1]), .req_ready(rdy[1]), .req_wen(w[1]),
    .req_addr(ad[1]), .req_wdata(wd[1]), .req_be(bes[1]),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]), .busy(bsy[1]));

  slave_mem_pipelined #(.WAIT_STATES(2)) u_c (
    .clk(clk), .rst(rst[2]), .req_valid(v[2]), .req_ready(rdy[2]), .req_wen(w[2]),
    .req_addr(ad[2][11:0]), .req_wdata(wd[2]), .req_be(bes[2]),
    .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .rsp_err(re[2]), .busy(bsy[2]));

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  function automatic int sb_size(input int d);
    case (d)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic exp_t sb_pop(input int d);
    case (d)
      0:       return qa.pop_front();
      1:       return qb.pop_front();
      default: return qc.pop_front();
    endcase
  endfunction

  task automatic sb_push(input int d, input logic err, input logic [31:0] data, input int at);
    exp_t e;
    e.err  = err;
    e.data = data;
    e.at   = at;
    case (d)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (rv[d] === 1'b1) begin
        if (sb_size(d) == 0) begin
          chk($sformatf("d%0d_unexpected_rsp", d), 1, 0);
        end else begin
          e = sb_pop(d);
          chk($sformatf("d%0d_rsp_err", d), re[d], e.err);
          chk($sformatf("d%0d_rsp_data", d), rd[d], e.data);
          chk($sformatf("d%0d_rsp_cycle", d), cyc, e.at);
        end
      end
    end
  end

  // Drives one request from the next falling edge and holds it until req_ready is seen.
  task automatic do_req(input int d, input logic wen, input logic [12:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic exp_err, input logic [31:0] exp_data);
    int n = 0;
    @(negedge clk);
    v[d] = 1'b1; w[d] = wen; ad[d] = addr; wd[d] = wdata; bes[d] = be;
    while (rdy[d] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rdy[d] !== 1'b1) chk($sformatf("d%0d_accept_timeout", d), rdy[d], 1);
    else                 sb_push(d, exp_err, exp_data, cyc + lat(d));
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    v[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n = 0;
    while (sb_size(d) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d%0d_drain", d), sb_size(d), 0);
  endtask

  task automatic count_init(input int d, output int n_lo, output int n_busy, output int n_rv);
    n_lo = 0; n_busy = 0; n_rv = 0;
    while (rdy[d] !== 1'b1 && n_lo < 5000) begin
      n_lo++;
      if (bsy[d] === 1'b1) n_busy++;
      if (rv[d] === 1'b1)  n_rv++;
      @(negedge clk);
    end
  endtask

  // Read of 0x000 on the wait-state instance; valid dropped at cycle 'hold' (9 = held to the end).
  task automatic ws_run(input int hold, output logic [8:0] rmask, output logic [8:0] vmask);
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) begin
        v[2] = 1'b1; w[2] = 1'b0; ad[2] = 13'h000; bes[2] = 4'h0;
        if (hold == 9) begin
          sb_push(2, 1'b0, 32'h0, cyc + 4);
          sb_push(2, 1'b0, 32'h0, cyc + 8);
        end
      end
      if (k == hold) v[2] = 1'b0;
      rmask[k] = rdy[2];
      vmask[k] = rv[2];
    end
    v[2] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int n_lo, n_busy, n_rv;
    logic [8:0] rm, vm;
    rst = 3'b111; v = '0; w = '0;
    for (int d = 0; d < 3; d++) begin
      ad[d] = '0; wd[d] = '0; bes[d] = '0;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_rst_ready", d), rdy[d], 0);
      chk($sformatf("d%0d_rst_rsp_valid", d), rv[d], 0);
      chk($sformatf("d%0d_rst_rsp_err", d), re[d], 0);
      chk($sformatf("d%0d_rst_rsp_rdata", d), rd[d], 0);
      chk($sformatf("d%0d_rst_busy", d), bsy[d], 1);
    end
    @(negedge clk);
    rst = 3'b000;
    count_init(0, n_lo, n_busy, n_rv);
    chk("a_init_ready_low_cycles", n_lo, 1024);
    chk("a_init_busy_cycles", n_busy, 1024);
    chk("a_busy_after_init", bsy[0], 0);
    chk("b_ready_after_init", rdy[1], 1);
    chk("c_ready_after_init", rdy[2], 0);
    chk("c_busy_after_init", bsy[2], 0);

    do_req(0, 1'b0, 13'h000, 32'h0, 4'h0, 1'b0, 32'h0);
    do_req(0, 1'b0, 13'hFFC, 32'h0, 4'h0, 1'b0, 32'h0);
    do_req(0, 1'b1, 13'h010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    do_req(0, 1'b1, 13'h010, 32'h11223344, 4'b0101, 1'b0, 32'h0);
    do_req(0, 1'b0, 13'h010, 32'h0, 4'h0, 1'b0, 32'hDE22BE44);
    do_req(0, 1'b1, 13'h010, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0);
    do_req(0, 1'b0, 13'h013, 32'h0, 4'h0, 1'b0, 32'hDE22BE44);
    idle(0);
    drain(0);
    @(negedge clk);
    chk("a_busy_after_drain", bsy[0], 0);

    do_req(1, 1'b0, 13'h1000, 32'h0, 4'h0, 1'b1, 32'h0);
    do_req(1, 1'b1, 13'h1000, 32'hFF, 4'hF, 1'b1, 32'h0);
    do_req(1, 1'b0, 13'h0000, 32'h0, 4'h0, 1'b0, 32'h0);
    do_req(1, 1'b0, 13'h1FFC, 32'h0, 4'h0, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) do_req(1, 1'b1, 13'(4 * i), 32'(i + 1), 4'hF, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) do_req(1, 1'b0, 13'(4 * i), 32'h0, 4'h0, 1'b0, 32'(i + 1));
    idle(1);
    drain(1);
    @(negedge clk);
    chk("b_busy_after_drain", bsy[1], 0);

    @(negedge clk);
    v[1] = 1'b1; w[1] = 1'b0; ad[1] = 13'h004;
    chk("b_ready_before_rst", rdy[1], 1);
    @(negedge clk);
    v[1] = 1'b0; rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("b_midrst_busy", bsy[1], 1);
    chk("b_midrst_ready", rdy[1], 0);
    chk("b_midrst_rsp_valid", rv[1], 0);
    count_init(1, n_lo, n_busy, n_rv);
    chk("b_reinit_ready_low_cycles", n_lo, 1024);
    chk("b_reinit_dropped_rsp", n_rv, 0);
    do_req(1, 1'b0, 13'h004, 32'h0, 4'h0, 1'b0, 32'h0);
    idle(1);
    drain(1);

    ws_run(9, rm, vm);
    chk("c_held_ready_pattern", rm, 9'h088);
    chk("c_held_rsp_pattern", vm, 9'h110);
    drain(2);
    ws_run(1, rm, vm);
    chk("c_withdrawn_ready_pattern", rm, 9'h008);
    chk("c_withdrawn_rsp_pattern", vm, 9'h000);
    do_req(2, 1'b1, 13'h020, 32'hA5A5A5A5, 4'b0011, 1'b0, 32'h0);
    do_req(2, 1'b0, 13'h020, 32'h0, 4'h0, 1'b0, 32'h0000A5A5);
    idle(2);
    drain(2);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
